// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and framing constants.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DATA_BITS            = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous serial input; resets to the idle-high level.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sync <= '1;
    end else begin
      r_sync <= (r_sync << 1) | SYNC_STAGES'(i_async);
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver presenting the last correctly framed byte on bus.
// Define UART_RX_DEBUG_EN to expose the live FSM state on cur_state.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] bus
`ifdef UART_RX_DEBUG_EN
  ,
  output logic [2:0] cur_state
`endif
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_IDX = 3'(DATA_BITS - 1);

  logic             w_rxs;
  uart_state_t      r_state;
  logic [CNT_W-1:0] r_clkCnt;
  logic [2:0]       r_bitIdx;
  logic [7:0]       r_shift;
  logic [7:0]       r_bus;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rstn   (rstn),
    .i_async(rx),
    .o_sync (w_rxs)
  );

  // Start is qualified at mid start bit; every later sample lands one full bit period apart.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_clkCnt <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
      r_bus    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_clkCnt <= '0;
          if (!w_rxs) begin
            r_state <= START;
          end
        end
        START: begin
          if (r_clkCnt == HALF_M1) begin
            r_clkCnt <= '0;
            r_bitIdx <= '0;
            r_state  <= w_rxs ? IDLE : DATA;
          end else begin
            r_clkCnt <= r_clkCnt + 1'b1;
          end
        end
        DATA: begin
          if (r_clkCnt == FULL_M1) begin
            r_clkCnt          <= '0;
            r_shift[r_bitIdx] <= w_rxs;
            if (r_bitIdx == LAST_IDX) begin
              r_state <= STOP;
            end else begin
              r_bitIdx <= r_bitIdx + 3'd1;
            end
          end else begin
            r_clkCnt <= r_clkCnt + 1'b1;
          end
        end
        STOP: begin
          // Leaving at mid stop bit lets a start bit follow with no idle gap.
          if (r_clkCnt == FULL_M1) begin
            r_clkCnt <= '0;
            if (w_rxs) begin
              r_bus   <= r_shift;
              r_state <= IDLE;
            end else begin
              r_state <= WAIT_HIGH;
            end
          end else begin
            r_clkCnt <= r_clkCnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          r_clkCnt <= '0;
          if (w_rxs) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_clkCnt <= '0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign bus = r_bus;

`ifdef UART_RX_DEBUG_EN
  assign cur_state = r_state;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table-driven frames with a byte scoreboard plus corner sequences.
module tb_uart_receiver;
  import uart_pkg::*;

  // Reduced bit period keeps runtime short; sender runs one time unit slow per bit.
  localparam int CLKS     = 32;
  localparam int SYNC     = 2;
  localparam int CLK_HALF = 10;
  localparam int BIT_T    = CLKS * 2 * CLK_HALF + 1;

  typedef struct {
    logic [7:0] data;
    logic       stopBit;
    int         gapBits;
    logic [7:0] expBus;
  } vec_t;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       rx   = 1'b1;
  logic [7:0] bus;
`ifdef UART_RX_DEBUG_EN
  logic [2:0] cur_state;
`endif

  int         testsRun    = 0;
  int         testsFailed = 0;
  logic [7:0] expQ[$];
  vec_t       vecs[$];
  event       stopMid;

  uart_receiver #(
    .CLKS_PER_BIT(CLKS),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .rx  (rx),
    .bus (bus)
`ifdef UART_RX_DEBUG_EN
    ,
    .cur_state(cur_state)
`endif
  );

  always #CLK_HALF clk = ~clk;

  function automatic vec_t makeVec(logic [7:0] data, logic stopBit, int gapBits, logic [7:0] expBus);
    vec_t v;
    v.data    = data;
    v.stopBit = stopBit;
    v.gapBits = gapBits;
    v.expBus  = expBus;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkState(input string name, input logic [2:0] expected);
    logic [2:0] st;
    st = dut.r_state;
    checkOutput(name, {5'b0, st}, {5'b0, expected});
  endtask

  // Full 8N1 frame; the scoreboard is told when the stop bit is three quarters through.
  task automatic sendFrame(input logic [7:0] data, input logic stopBit);
    rx = 1'b0;
    #BIT_T;
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      #BIT_T;
    end
    rx = stopBit;
    #(BIT_T * 3 / 4);
    -> stopMid;
    #(BIT_T - BIT_T * 3 / 4);
  endtask

  task automatic applyStimulus(input vec_t v);
    rx = 1'b1;
    #(BIT_T * v.gapBits);
    expQ.push_back(v.expBus);
    sendFrame(v.data, v.stopBit);
  endtask

  task automatic runVectors(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      applyStimulus(vecs[i]);
    end
  endtask

  // Scoreboard: each frame's expected bus value is compared before its stop bit ends.
  initial begin
    forever begin
      @(stopMid);
      @(negedge clk);
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL scoreboard: got frame with no expectation, expected queued byte");
      end else begin
        checkOutput("frame byte", bus, expQ.pop_front());
      end
    end
  end

  initial begin
    #(BIT_T * 400);
    $display("[TB] FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "[TB] time limit exceeded");
  end

  initial begin
    vecs.push_back(makeVec(8'h48, 1'b1, 2, 8'h48));
    vecs.push_back(makeVec(8'h48, 1'b1, 1, 8'h48));
    vecs.push_back(makeVec(8'h65, 1'b1, 0, 8'h65));
    vecs.push_back(makeVec(8'h6C, 1'b1, 0, 8'h6C));
    vecs.push_back(makeVec(8'h6C, 1'b1, 0, 8'h6C));
    vecs.push_back(makeVec(8'h6F, 1'b1, 0, 8'h6F));
    vecs.push_back(makeVec(8'h2C, 1'b1, 0, 8'h2C));
    vecs.push_back(makeVec(8'h20, 1'b1, 0, 8'h20));
    vecs.push_back(makeVec(8'h57, 1'b1, 0, 8'h57));
    vecs.push_back(makeVec(8'h6F, 1'b1, 0, 8'h6F));
    vecs.push_back(makeVec(8'h72, 1'b1, 0, 8'h72));
    vecs.push_back(makeVec(8'h6C, 1'b1, 0, 8'h6C));
    vecs.push_back(makeVec(8'h64, 1'b1, 0, 8'h64));
    vecs.push_back(makeVec(8'h21, 1'b1, 0, 8'h21));
    vecs.push_back(makeVec(8'hA5, 1'b0, 1, 8'h21));
    vecs.push_back(makeVec(8'h3C, 1'b1, 2, 8'h3C));
    vecs.push_back(makeVec(8'h00, 1'b1, 2, 8'h00));

    rx   = 1'b1;
    rstn = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("reset bus", bus, 8'h00);
    checkState("reset state", 3'(IDLE));
    rstn = 1'b1;

    runVectors(0, 0);

    // 100-unit glitch must be rejected at mid start bit without touching bus.
    @(negedge clk);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (CLKS / 2 + 3 + SYNC - 5 + 1) @(negedge clk);
    checkState("glitch state", 3'(IDLE));
    checkOutput("glitch bus", bus, 8'h48);

    runVectors(1, 13);
    runVectors(14, 15);

    // Abort 8'hFF during data bit 4; remaining bits are high so no false start follows.
    rx = 1'b1;
    #(BIT_T * 2);
    rx = 1'b0;
    #BIT_T;
    rx = 1'b1;
    #(BIT_T * 4 + BIT_T / 2);
    @(negedge clk);
    rstn = 1'b0;
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("mid-frame reset bus", bus, 8'h00);
    checkState("mid-frame reset state", 3'(IDLE));
    #(BIT_T * 5);

    runVectors(16, 16);

    rx = 1'b1;
    #(BIT_T * 2);
    @(negedge clk);
    checkOutput("scoreboard drained", 8'(expQ.size()), 8'h00);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
